// File: rtl/mul_seq.sv
// Sequential unsigned 16x16->32 multiplier that borrows the shared lu adder for
// one shift-and-add step per cycle, then presents the product with a done pulse.
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] lu_a,
    output logic [15:0] lu_b,
    output logic        lu_cin,
    output logic [1:0]  lu_op,
    input  logic [15:0] lu_sum,
    input  logic        lu_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg,  state_next;
    logic [15:0] m_reg,      m_next;
    logic [15:0] acc_hi_reg, acc_hi_next;
    logic [15:0] acc_lo_reg, acc_lo_next;
    logic [3:0]  cnt_reg,    cnt_next;
    logic [31:0] result_reg, result_next;

    // Partial product for this step: the multiplicand gated by the current
    // multiplier bit, which always sits in acc_lo[0].
    logic [15:0] addend;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_addend
            assign addend[gi] = m_reg[gi] & acc_lo_reg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            m_reg      <= 16'h0000;
            acc_hi_reg <= 16'h0000;
            acc_lo_reg <= 16'h0000;
            cnt_reg    <= 4'd0;
            result_reg <= 32'h0000_0000;
        end else begin
            state_reg  <= state_next;
            m_reg      <= m_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        m_next      = m_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        lu_a        = 16'h0000;
        lu_b        = 16'h0000;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next      = op_a;
                    acc_hi_next = 16'h0000;
                    acc_lo_next = op_b;
                    cnt_next    = 4'd0;
                    state_next  = ITER;
                end
            end
            ITER: begin
                lu_a = acc_hi_reg;
                lu_b = addend;
                // Shift the 17-bit sum right into the accumulator; the carry
                // becomes the new top bit so no product bit is lost.
                acc_hi_next = {lu_cout, lu_sum[15:1]};
                acc_lo_next = {lu_sum[0], acc_lo_reg[15:1]};
                if (cnt_reg == 4'd15) begin
                    result_next = {lu_cout, lu_sum[15:1], lu_sum[0], acc_lo_reg[15:1]};
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state_reg == ITER);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign lu_cin = 1'b0;
    assign lu_op  = 2'b00;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: a stand-in lu adder, an arithmetic model
// compared every cycle, and directed plus random multiplications.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;
    logic [15:0] lu_a, lu_b, lu_sum;
    logic        lu_cin, lu_cout;
    logic [1:0]  lu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .lu_a    (lu_a),
        .lu_b    (lu_b),
        .lu_cin  (lu_cin),
        .lu_op   (lu_op),
        .lu_sum  (lu_sum),
        .lu_cout (lu_cout)
    );

    // Stand-in for the combinational logic unit in add mode.
    logic [16:0] lu_full;
    assign lu_full = {1'b0, lu_a} + {1'b0, lu_b} + {16'h0000, lu_cin};
    assign lu_sum  = lu_full[15:0];
    assign lu_cout = lu_full[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..16 = iteration number, 17 = done.
    int          phase = 0;
    logic [15:0] ma = '0, mb = '0;
    logic [31:0] exp_result = '0;
    int          cycle = 0;
    bit          checking = 1'b0;

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            phase      = 0;
            exp_result = 32'h0;
        end else if (phase == 0) begin
            if (start) begin
                ma    = op_a;
                mb    = op_b;
                phase = 1;
            end
        end else if (phase == 17) begin
            phase = 0;
        end else begin
            phase = phase + 1;
            if (phase == 17) exp_result = ma * mb;
        end
    end

    always @(negedge clk) begin
        logic [31:0] mask, part, exp_hi, exp_b;
        int j;
        if (checking) begin
            chk("busy", {31'b0, busy}, {31'b0, (phase >= 1 && phase <= 16)});
            chk("done", {31'b0, done}, {31'b0, (phase == 17)});
            chk("lu_ctl", {29'b0, lu_op, lu_cin}, 32'h0);
            if (phase >= 1 && phase <= 16) begin
                j      = phase - 1;
                mask   = (32'd1 << j) - 32'd1;
                part   = {16'h0, ma} * ({16'h0, mb} & mask);
                exp_hi = part >> j;
                exp_b  = mb[j] ? {16'h0, ma} : 32'h0;
                chk("lu_a_iter", {16'h0, lu_a}, exp_hi);
                chk("lu_b_iter", {16'h0, lu_b}, exp_b);
            end else begin
                chk("lu_ab_idle", {lu_a, lu_b}, 32'h0);
                chk("result_hold", result, exp_result);
            end
        end
    end

    task automatic start_mul(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
    endtask

    // Waits (bounded) for done; counts cycles, busy cycles and nonzero lu_b.
    task automatic wait_done(output int n_cyc, output int n_busy, output int n_lub);
        n_cyc  = 0;
        n_busy = 0;
        n_lub  = 0;
        do begin
            @(negedge clk);
            n_cyc++;
            if (busy) n_busy++;
            if (busy && lu_b != 16'h0) n_lub++;
        end while (!done && n_cyc < 60);
        if (!done) chk("done_timeout", 32'(n_cyc), 32'd17);
    endtask

    int nc, nb, nl, last_cyc;
    logic [15:0] ra, rb;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1 checking = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_result", result, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 3 x 5: latency and busy width
        start_mul(16'd3, 16'd5);
        wait_done(nc, nb, nl);
        chk("lat_3x5", 32'(nc), 32'd17);
        chk("busy_cycles_3x5", 32'(nb), 32'd16);
        chk("res_3x5", result, 32'h0000_000F);
        $display("mul 0003 x 0005 -> %h (%0d cycles)", result, nc);

        start_mul(16'hFFFF, 16'hFFFF);
        wait_done(nc, nb, nl);
        chk("res_ffff_ffff", result, 32'hFFFE_0001);
        $display("mul ffff x ffff -> %h", result);

        start_mul(16'h8000, 16'h0002);
        wait_done(nc, nb, nl);
        chk("res_8000_2", result, 32'h0001_0000);
        $display("mul 8000 x 0002 -> %h", result);

        start_mul(16'h0000, 16'h1234);
        wait_done(nc, nb, nl);
        chk("res_0_1234", result, 32'h0);
        chk("lu_b_zero_cycles", 32'(nl), 32'd0);
        $display("mul 0000 x 1234 -> %h", result);

        // 7 x 9 with stray starts in ITER and DONE
        start_mul(16'd7, 16'd9);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; op_a = 16'd100; op_b = 16'd100;
        @(posedge clk); #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        chk("done_7x9", {31'b0, done}, 32'h1);
        chk("res_7x9", result, 32'd63);
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy_7x9", {31'b0, busy}, 32'h0);
            chk("hold_7x9", result, 32'd63);
        end
        $display("mul 0007 x 0009 -> %h (stray starts ignored)", result);

        // Reset during ITER cycle 8
        start_mul(16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_result", result, 32'h0);
        nl = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nl++;
        end
        chk("abort_no_done", 32'(nl), 32'h0);
        $display("abort 1234 x 5678 -> result %h", result);
        start_mul(16'h1234, 16'h5678);
        wait_done(nc, nb, nl);
        chk("res_1234_5678", result, 32'h0626_0060);
        $display("mul 1234 x 5678 -> %h", result);

        // Back-to-back with start held high
        @(posedge clk); #1;
        op_a = 16'h00FF; op_b = 16'h0101; start = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(nc, nb, nl);
            chk("res_b2b", result, 32'h0000_FFFF);
            if (k > 0) chk("b2b_period", 32'(cycle - last_cyc), 32'd18);
            $display("b2b %0d: 00ff x 0101 -> %h at cycle %0d", k, result, cycle);
            last_cyc = cycle;
        end
        @(posedge clk); #1 start = 1'b0;

        // Random products with random idle gaps
        for (int i = 0; i < 40; i++) begin
            case (i % 5)
                0:       begin ra = 16'($urandom); rb = 16'($urandom); end
                1:       begin ra = 16'hFFFF;      rb = 16'($urandom); end
                2:       begin ra = 16'($urandom); rb = 16'hFFFF;      end
                default: begin ra = 16'($urandom); rb = 16'($urandom_range(0, 255)); end
            endcase
            start_mul(ra, rb);
            wait_done(nc, nb, nl);
            chk("res_rand", result, {16'h0, ra} * {16'h0, rb});
            $display("rand %0d: %h x %h -> %h", i, ra, rb, result);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
